digdug_cus06_ctrl: RTL and testbench
====================================

# digdug_cus06_ctrl

Bus-interface sequencer between the main CPU and the DigDug custom chips (I/O, DIP-switch, and spare slots). It owns the control register, which holds the chip-select mask, direction and NMI enable. It forwards CPU command and data writes to every selected chip in turn, and performs single-chip reads into a registered return byte. It also generates the periodic CPU NMI that paces the I/O protocol.

## Interface
- NMI_PERIOD, 2400: NMI timer period in CL cycles (≥ NMI_WIDTH+2).
- NMI_WIDTH, 200: NMI high time in CL cycles, at end of period.
- CL  in  1  system clock; all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- CPU_CS  in  1  single-cycle access strobe.
- CPU_WR  in  1  1=write, 0=read; qualified by CPU_CS.
- CPU_AD  in  5  [4]=1 control register, else data index [3:0].
- CPU_DI  in  8  CPU write data.
- CPU_DO  out  8  AD[4]=1: control register (combinational); else RDATA (registered).
- CPU_WAIT  out  1  sequencer busy or request pending.
- DROP  out  1  sticky: a strobe was lost; cleared by control write.
- NMI  out  1  periodic NMI.
- CHIP_CS  out  4  one-hot chip select, one cycle per transfer.
- CHIP_WR  out  1  write qualifier for CHIP_CS.
- CHIP_AD  out  5  chip address ({1,0000} for command, {0,idx} for data).
- CHIP_DO  out  8  data to chip.
- CHIP_DI  in  32  read lanes, chip i on [8i+7:8i].

## Operation
- CTRL bits: [3:0] MASK, [4] RDMODE, [7:5] NMIEN (non-zero = run). Reset value 8'h00.
- States: IDLE, BCAST, READ, CAPT.
- Accepting a request:
  - A strobe is accepted from IDLE.
  - If the sequencer is not idle, the strobe goes into a one-deep pending slot.
  - A strobe that arrives while the slot is full is discarded and sets DROP.
  - The pending request starts on the cycle after the sequencer returns to IDLE.
- Control write:
  - CTRL <= DI at acceptance.
  - The NMI counter clears.
  - Enters BCAST with payload DI and address 5'h10.
- Data write:
  - Ignored (no BCAST) when RDMODE=1.
  - Otherwise enters BCAST with payload DI and address {0,idx}.
- BCAST:
  - One cycle per set MASK bit, ascending chip index.
  - In each of those cycles: CHIP_CS=one-hot, CHIP_WR=1, CHIP_AD and CHIP_DO held.
  - Returns to IDLE after the highest set bit.
  - MASK==0 means zero chip cycles: back to IDLE the next cycle.
  - The mask is snapshotted at BCAST entry.
- Data read: READ drives CHIP_CS for the lowest set MASK bit, with CHIP_WR=0 and CHIP_AD={0,idx}. CAPT then latches that lane into RDATA. MASK==0 latches 8'hFF.
- A control read needs no sequencing and is never queued.
- NMI:
  - While NMIEN≠0, the counter runs 0..NMI_PERIOD-1 and wraps.
  - NMI=1 when count ≥ NMI_PERIOD-NMI_WIDTH.
  - While NMIEN==0, the counter is held at 0 and NMI=0.
- Outputs in IDLE: CHIP_CS=0, CHIP_WR=0; CHIP_AD and CHIP_DO hold their last values.
- Reset: CTRL=0, state=IDLE, pending empty, DROP=0, NMI=0, CHIP_CS=0, CHIP_WR=0, CHIP_AD=0, CHIP_DO=0, RDATA=8'hFF, CPU_WAIT=0, counter=0.
- Reset mid-transfer aborts it immediately. No partial strobe survives.

## Timing
- Strobe at cycle t, accepted from IDLE:
  - The first CHIP_CS is at t+1.
  - A broadcast to N chips occupies t+1..t+N.
  - CPU_WAIT=1 over t+1..t+N, IDLE at t+N+1.
- Read strobe at t: CHIP_CS at t+1, RDATA valid at t+2, CPU_WAIT=1 for t+1..t+2.
- A control write while a broadcast is running is queued. CTRL changes only when that control write is accepted, never mid-broadcast.
- NMI is a registered output, with a first rising edge NMI_PERIOD-NMI_WIDTH cycles after the enabling write.

## Structure
- Package digdug_cus06_pkg holds:
  - the state enum;
  - CTRL field positions;
  - the command address 5'h10;
  - the RDATA reset value 8'hFF.
- Sub-module digdug_nmi_timer (parameters NMI_PERIOD, NMI_WIDTH; inputs en and clr; output nmi), instantiated once.
- Mask scanning ("next set bit above i") is a package function.

## Test plan
- Reset, write CTRL=8'hE3 -> NMI rises 2200 cycles after the write, is high for 200 cycles, period 2400; write 8'h10 -> NMI=0 the next cycle and stays low.
- CTRL=8'h0A, data write idx 8 DI=8'h5C -> CHIP_CS=4'b0010 then 4'b1000 on consecutive cycles, CHIP_WR=1, CHIP_AD=5'h08, CHIP_DO=8'h5C, CPU_WAIT high for 2 cycles.
- CTRL=8'h75 (read mode, chips 0 and 2), CHIP_DI lanes 0/2 = 8'hA1/8'h3C, read idx 1 -> CHIP_CS=4'b0001 with AD=5'h01, CPU_DO=8'hA1 two cycles after the strobe; a data write in this mode produces no CHIP_CS.
- CTRL=8'h0F, three back-to-back write strobes -> first runs, second is queued and runs right after, third is dropped, DROP=1; a following control write clears DROP.
- CTRL=8'h00, read -> no CHIP_CS, CPU_DO=8'hFF; a control read returns 8'h00 with zero wait.
- Assert RESET during the second chip cycle of a 4-chip broadcast -> CHIP_CS=0 and all outputs at reset values immediately; no transfer resumes after release.

Source files
------------

// File: rtl/digdug_cus06_pkg.sv
// digdug_cus06_pkg
// Shared definitions for the DigDug CUS06 bus-interface sequencer:
//   - state_t     : sequencer states
//   - req_t       : one captured CPU strobe (write flag, address, data)
//   - scan_t      : result of a mask scan (found flag + chip index)
//   - CTRL field positions, command address, RDATA reset value
//   - scan_from() : lowest set mask bit at or above a given chip index
package digdug_cus06_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BCAST = 2'd1,
        READ  = 2'd2,
        CAPT  = 2'd3
    } state_t;

    localparam int CTRL_MASK_LSB  = 0;
    localparam int CTRL_RDMODE    = 4;
    localparam int CTRL_NMIEN_LSB = 5;

    localparam logic [4:0] CMD_ADDR    = 5'h10;
    localparam logic [7:0] RDATA_RESET = 8'hFF;

    typedef struct packed {
        logic       wr;
        logic [4:0] ad;
        logic [7:0] di;
    } req_t;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } scan_t;

    // Scanning downwards lets the lowest qualifying bit overwrite any higher one.
    function automatic scan_t scan_from(input logic [3:0] mask, input logic [2:0] start);
        scan_t r;
        r = '0;
        for (int i = 3; i >= 0; i--) begin
            if ((3'(i) >= start) && mask[i]) begin
                r.found = 1'b1;
                r.idx   = 2'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/digdug_nmi_timer.sv
// digdug_nmi_timer
// Free-running NMI pacer. Counts 0..NMI_PERIOD-1 while enabled and drives a
// registered NMI that is high for the last NMI_WIDTH counts of each period.
// Ports:
//   CL    in  system clock
//   RESET in  asynchronous active-high reset
//   en    in  counter runs when 1, held at 0 (NMI low) when 0
//   clr   in  restart the period from count 0
//   nmi   out registered NMI
module digdug_nmi_timer #(
    parameter int NMI_PERIOD = 2400,
    parameter int NMI_WIDTH  = 200
) (
    input  logic CL,
    input  logic RESET,
    input  logic en,
    input  logic clr,
    output logic nmi
);

    localparam int            CW        = $clog2(NMI_PERIOD);
    localparam logic [CW-1:0] LAST      = CW'(NMI_PERIOD - 1);
    localparam logic [CW-1:0] HIGH_FROM = CW'(NMI_PERIOD - NMI_WIDTH);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;

    always_comb begin
        cnt_nx = (cnt == LAST) ? '0 : cnt + CW'(1);
    end

    // NMI is computed from the value the counter is about to hold, so the
    // registered output lines up with the count rather than lagging it.
    always_ff @(posedge CL or posedge RESET) begin
        if (RESET) begin
            cnt <= '0;
            nmi <= 1'b0;
        end else if (clr || !en) begin
            cnt <= '0;
            nmi <= 1'b0;
        end else begin
            cnt <= cnt_nx;
            nmi <= (cnt_nx >= HIGH_FROM);
        end
    end

endmodule

// File: rtl/digdug_cus06_ctrl.sv
// digdug_cus06_ctrl
// Sequencer between the main CPU and the DigDug custom chips. Holds the
// control register (chip mask, read mode, NMI enable), fans CPU writes out to
// every selected chip, performs single-chip reads into RDATA and paces the
// CPU with a periodic NMI.
// Ports:
//   CL, RESET          clock, asynchronous active-high reset
//   CPU_CS/WR/AD/DI    single-cycle CPU access strobe
//   CPU_DO             control register (AD[4]=1) or RDATA
//   CPU_WAIT           sequencer busy or request pending
//   DROP               sticky lost-strobe flag, cleared by a control write
//   NMI                periodic CPU NMI
//   CHIP_CS/WR/AD/DO   chip-side transfer, one chip per cycle
//   CHIP_DI            read lanes, chip i on [8i+7:8i]
module digdug_cus06_ctrl
    import digdug_cus06_pkg::*;
#(
    parameter int NMI_PERIOD = 2400,
    parameter int NMI_WIDTH  = 200
) (
    input  logic        CL,
    input  logic        RESET,
    input  logic        CPU_CS,
    input  logic        CPU_WR,
    input  logic [4:0]  CPU_AD,
    input  logic [7:0]  CPU_DI,
    output logic [7:0]  CPU_DO,
    output logic        CPU_WAIT,
    output logic        DROP,
    output logic        NMI,
    output logic [3:0]  CHIP_CS,
    output logic        CHIP_WR,
    output logic [4:0]  CHIP_AD,
    output logic [7:0]  CHIP_DO,
    input  logic [31:0] CHIP_DI
);

    state_t     state, state_nx;
    logic [7:0] ctrl;
    logic [3:0] mask_snap;
    logic [1:0] cur_idx;
    logic       pend_valid;
    req_t       pend;
    logic       drop;
    logic [4:0] chip_ad_q;
    logic [7:0] chip_do_q;
    logic [7:0] rdata;

    req_t       new_req, start_req;
    logic       seq_strobe, start_pend, take_new, start_valid;
    logic       queue_new, drop_new;
    logic       start_ctrl_wr, start_data_wr, start_read;
    logic [3:0] start_mask;
    scan_t      first_bit, next_bit;

    assign new_req = {CPU_WR, CPU_AD, CPU_DI};

    // Request arbitration. Control reads are served combinationally and never
    // enter the sequencer. From IDLE a pending request has priority; a strobe
    // arriving in that same cycle refills the slot being vacated.
    always_comb begin
        seq_strobe  = CPU_CS && (CPU_WR || !CPU_AD[4]);
        start_pend  = (state == IDLE) && pend_valid;
        take_new    = (state == IDLE) && !pend_valid && seq_strobe;
        start_valid = start_pend || take_new;
        start_req   = pend_valid ? pend : new_req;
        queue_new   = seq_strobe && !take_new && (!pend_valid || start_pend);
        drop_new    = seq_strobe && !take_new && pend_valid && !start_pend;

        start_ctrl_wr = start_valid && start_req.wr && start_req.ad[4];
        start_data_wr = start_valid && start_req.wr && !start_req.ad[4]
                        && !ctrl[CTRL_RDMODE];
        start_read    = start_valid && !start_req.wr;

        // A control write broadcasts to the mask it is itself installing.
        start_mask = start_ctrl_wr ? start_req.di[3:0] : ctrl[CTRL_MASK_LSB +: 4];
        first_bit  = scan_from(start_mask, 3'd0);
        next_bit   = scan_from(mask_snap, {1'b0, cur_idx} + 3'd1);
    end

    always_ff @(posedge CL or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // An empty mask produces no chip cycles, so such writes never leave IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if ((start_ctrl_wr || start_data_wr) && first_bit.found) begin
                    state_nx = BCAST;
                end else if (start_read) begin
                    state_nx = READ;
                end
            end
            BCAST:   if (!next_bit.found) state_nx = IDLE;
            READ:    state_nx = CAPT;
            CAPT:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        CHIP_CS = 4'b0000;
        CHIP_WR = 1'b0;
        case (state)
            BCAST: begin
                CHIP_CS = 4'b0001 << cur_idx;
                CHIP_WR = 1'b1;
            end
            READ: begin
                if (mask_snap != 4'b0000) CHIP_CS = 4'b0001 << cur_idx;
            end
            default: ;
        endcase
    end

    // Datapath: control register, pending slot, chip address/data, RDATA.
    // The lane is sampled at the end of READ so RDATA is already valid in CAPT.
    always_ff @(posedge CL or posedge RESET) begin
        if (RESET) begin
            ctrl       <= 8'h00;
            drop       <= 1'b0;
            pend_valid <= 1'b0;
            pend       <= '0;
            mask_snap  <= 4'b0000;
            cur_idx    <= 2'd0;
            chip_ad_q  <= 5'h00;
            chip_do_q  <= 8'h00;
            rdata      <= RDATA_RESET;
        end else begin
            if (start_ctrl_wr) ctrl <= start_req.di;

            if (start_ctrl_wr)  drop <= 1'b0;
            else if (drop_new)  drop <= 1'b1;

            if (start_pend) pend_valid <= 1'b0;
            if (queue_new) begin
                pend_valid <= 1'b1;
                pend       <= new_req;
            end

            if ((state == IDLE) && (state_nx != IDLE)) begin
                mask_snap <= start_mask;
                cur_idx   <= first_bit.idx;
                chip_ad_q <= start_ctrl_wr ? CMD_ADDR : {1'b0, start_req.ad[3:0]};
                if (!start_read) chip_do_q <= start_req.di;
            end

            if ((state == BCAST) && next_bit.found) cur_idx <= next_bit.idx;

            if (state == READ) begin
                rdata <= (mask_snap == 4'b0000) ? RDATA_RESET
                                                : CHIP_DI[{cur_idx, 3'b000} +: 8];
            end
        end
    end

    digdug_nmi_timer #(
        .NMI_PERIOD (NMI_PERIOD),
        .NMI_WIDTH  (NMI_WIDTH)
    ) u_nmi_timer (
        .CL    (CL),
        .RESET (RESET),
        .en    (|ctrl[CTRL_NMIEN_LSB +: 3]),
        .clr   (start_ctrl_wr),
        .nmi   (NMI)
    );

    assign CHIP_AD  = chip_ad_q;
    assign CHIP_DO  = chip_do_q;
    assign DROP     = drop;
    assign CPU_WAIT = (state != IDLE) || pend_valid;
    assign CPU_DO   = CPU_AD[4] ? ctrl : rdata;

endmodule

// File: tb/tb_digdug_cus06_ctrl.sv
// tb_digdug_cus06_ctrl
// Self-checking bench for digdug_cus06_ctrl. Each task exercises one feature
// with randomized payloads and compares the DUT against expectations derived
// from the block's rules (mask bit order, lowest-set-bit lane, NMI phase).
module tb_digdug_cus06_ctrl;

    localparam int PERIOD = 2400;
    localparam int WIDTH  = 200;

    logic        CL = 1'b0;
    logic        RESET;
    logic        CPU_CS;
    logic        CPU_WR;
    logic [4:0]  CPU_AD;
    logic [7:0]  CPU_DI;
    logic [7:0]  CPU_DO;
    logic        CPU_WAIT;
    logic        DROP;
    logic        NMI;
    logic [3:0]  CHIP_CS;
    logic        CHIP_WR;
    logic [4:0]  CHIP_AD;
    logic [7:0]  CHIP_DO;
    logic [31:0] CHIP_DI;

    int total = 0;
    int bad   = 0;

    digdug_cus06_ctrl #(
        .NMI_PERIOD (PERIOD),
        .NMI_WIDTH  (WIDTH)
    ) dut (
        .CL       (CL),
        .RESET    (RESET),
        .CPU_CS   (CPU_CS),
        .CPU_WR   (CPU_WR),
        .CPU_AD   (CPU_AD),
        .CPU_DI   (CPU_DI),
        .CPU_DO   (CPU_DO),
        .CPU_WAIT (CPU_WAIT),
        .DROP     (DROP),
        .NMI      (NMI),
        .CHIP_CS  (CHIP_CS),
        .CHIP_WR  (CHIP_WR),
        .CHIP_AD  (CHIP_AD),
        .CHIP_DO  (CHIP_DO),
        .CHIP_DI  (CHIP_DI)
    );

    always #5 CL = ~CL;

    // Lowest set bit of a mask, isolated with two's-complement arithmetic.
    function automatic logic [3:0] lowest_onehot(input logic [3:0] m);
        return m & (~m + 4'd1);
    endfunction

    // A read returns the lane of the first selected chip, or FF with no chip.
    function automatic logic [7:0] model_read(input logic [3:0] m, input logic [31:0] lanes);
        for (int i = 0; i < 4; i++) begin
            if (m[i]) return lanes[i*8 +: 8];
        end
        return 8'hFF;
    endfunction

    task automatic step();
        @(posedge CL);
        #1;
    endtask

    task automatic strobe(input logic wr, input logic [4:0] ad, input logic [7:0] di);
        CPU_CS = 1'b1;
        CPU_WR = wr;
        CPU_AD = ad;
        CPU_DI = di;
        step();
        CPU_CS = 1'b0;
        CPU_WR = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (CPU_WAIT && n < 64) begin
            step();
            n++;
        end
        total++;
        if (CPU_WAIT !== 1'b0) begin
            bad++;
            $display("[TB] FAIL wait_idle: CPU_WAIT=%b after %0d cycles, required 0", CPU_WAIT, n);
        end
    endtask

    task automatic apply_reset();
        RESET  = 1'b1;
        CPU_CS = 1'b0;
        CPU_WR = 1'b0;
        CPU_AD = 5'h00;
        CPU_DI = 8'h00;
        step();
        step();
        RESET = 1'b0;
        step();
    endtask

    task automatic test_reset();
        RESET   = 1'b1;
        CPU_CS  = 1'b0;
        CPU_WR  = 1'b0;
        CPU_AD  = 5'h00;
        CPU_DI  = 8'h00;
        CHIP_DI = 32'h0;
        step();
        total++;
        if ({CHIP_CS, CHIP_WR, CHIP_AD, CHIP_DO, CPU_WAIT, DROP, NMI, CPU_DO} !==
            {4'h0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF}) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got %h required %h",
                {CHIP_CS, CHIP_WR, CHIP_AD, CHIP_DO, CPU_WAIT, DROP, NMI, CPU_DO},
                {4'h0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF});
        end
        RESET = 1'b0;
        CPU_AD = 5'h10;
        step();
        total++;
        if ({CPU_DO, CPU_WAIT, CHIP_CS} !== {8'h00, 1'b0, 4'h0}) begin
            bad++;
            $display("[TB] FAIL reset_ctrl: got %h required %h", {CPU_DO, CPU_WAIT, CHIP_CS}, {8'h00, 1'b0, 4'h0});
        end
    endtask

    task automatic test_broadcast();
        logic [7:0] cw;
        logic [7:0] dd;
        logic [3:0] idx;
        logic [3:0] m;
        for (int it = 0; it < 7; it++) begin
            if (it == 0) begin
                cw = 8'h0A; idx = 4'h8; dd = 8'h5C;
            end else begin
                cw  = {4'b0000, 4'($urandom_range(1, 15))};
                idx = 4'($urandom);
                dd  = 8'($urandom);
            end
            m = cw[3:0];
            for (int j = 0; j < 2; j++) begin
                logic [4:0] ad;
                logic [7:0] pay;
                ad  = (j == 0) ? 5'h10 : {1'b0, idx};
                pay = (j == 0) ? cw : dd;
                strobe(1'b1, ad, pay);
                for (int c = 0; c < 4; c++) begin
                    if (m[c]) begin
                        total++;
                        if ({CHIP_CS, CHIP_WR, CHIP_AD, CHIP_DO, CPU_WAIT} !==
                            {4'(1 << c), 1'b1, ad, pay, 1'b1}) begin
                            bad++;
                            $display("[TB] FAIL bcast_chip%0d: got %h required %h", c,
                                {CHIP_CS, CHIP_WR, CHIP_AD, CHIP_DO, CPU_WAIT},
                                {4'(1 << c), 1'b1, ad, pay, 1'b1});
                        end
                        step();
                    end
                end
                total++;
                if ({CHIP_CS, CHIP_WR, CHIP_AD, CHIP_DO, CPU_WAIT} !== {4'h0, 1'b0, ad, pay, 1'b0}) begin
                    bad++;
                    $display("[TB] FAIL bcast_idle: got %h required %h",
                        {CHIP_CS, CHIP_WR, CHIP_AD, CHIP_DO, CPU_WAIT}, {4'h0, 1'b0, ad, pay, 1'b0});
                end
                if (j == 0) begin
                    CPU_AD = 5'h10;
                    #1;
                    total++;
                    if (CPU_DO !== cw) begin
                        bad++;
                        $display("[TB] FAIL ctrl_readback: got %h required %h", CPU_DO, cw);
                    end
                end
            end
        end
    endtask

    task automatic test_read();
        logic [7:0]  cw;
        logic [31:0] lanes;
        logic [3:0]  idx;
        logic [7:0]  exp;
        for (int it = 0; it < 6; it++) begin
            if (it == 0) begin
                cw = 8'h75; lanes = $urandom; lanes[7:0] = 8'hA1; lanes[23:16] = 8'h3C; idx = 4'h1;
            end else begin
                cw = {3'b000, 1'b1, 4'($urandom_range(0, 15))}; lanes = $urandom; idx = 4'($urandom);
            end
            strobe(1'b1, 5'h10, cw);
            wait_idle();
            CHIP_DI = lanes;
            exp = model_read(cw[3:0], lanes);
            strobe(1'b0, {1'b0, idx}, 8'h00);
            total++;
            if ({CHIP_CS, CHIP_WR, CHIP_AD, CPU_WAIT} !== {lowest_onehot(cw[3:0]), 1'b0, 1'b0, idx, 1'b1}) begin
                bad++;
                $display("[TB] FAIL read_select: got %h required %h",
                    {CHIP_CS, CHIP_WR, CHIP_AD, CPU_WAIT}, {lowest_onehot(cw[3:0]), 1'b0, 1'b0, idx, 1'b1});
            end
            step();
            CHIP_DI = ~lanes;
            #1;
            total++;
            if ({CPU_DO, CHIP_CS, CPU_WAIT} !== {exp, 4'h0, 1'b1}) begin
                bad++;
                $display("[TB] FAIL read_data: got %h required %h", {CPU_DO, CHIP_CS, CPU_WAIT}, {exp, 4'h0, 1'b1});
            end
            step();
            total++;
            if ({CPU_DO, CPU_WAIT} !== {exp, 1'b0}) begin
                bad++;
                $display("[TB] FAIL read_done: got %h required %h", {CPU_DO, CPU_WAIT}, {exp, 1'b0});
            end
            strobe(1'b1, {1'b0, idx}, 8'($urandom));
            for (int c = 0; c < 3; c++) begin
                total++;
                if ({CHIP_CS, CPU_WAIT} !== 5'b0) begin
                    bad++;
                    $display("[TB] FAIL rdmode_write: got %b required 00000", {CHIP_CS, CPU_WAIT});
                end
                step();
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] bi [3];
        logic [7:0] bd [3];
        logic [7:0] newc;
        for (int it = 0; it < 2; it++) begin
            strobe(1'b1, 5'h10, 8'h0F);
            wait_idle();
            for (int k = 0; k < 3; k++) begin
                bi[k] = 4'($urandom);
                bd[k] = 8'($urandom);
            end
            for (int c = 0; c < 4; c++) begin
                if (c < 3) strobe(1'b1, {1'b0, bi[c]}, bd[c]);
                else step();
                total++;
                if ({CHIP_CS, CHIP_AD, CHIP_DO} !== {4'(1 << c), 1'b0, bi[0], bd[0]}) begin
                    bad++;
                    $display("[TB] FAIL b2b_first%0d: got %h required %h", c,
                        {CHIP_CS, CHIP_AD, CHIP_DO}, {4'(1 << c), 1'b0, bi[0], bd[0]});
                end
                if (c == 2) begin
                    total++;
                    if (DROP !== 1'b1) begin
                        bad++;
                        $display("[TB] FAIL b2b_drop_set: got %b required 1", DROP);
                    end
                end
            end
            step();
            total++;
            if ({CHIP_CS, CPU_WAIT} !== {4'h0, 1'b1}) begin
                bad++;
                $display("[TB] FAIL b2b_gap: got %b required 00001", {CHIP_CS, CPU_WAIT});
            end
            for (int c = 0; c < 4; c++) begin
                step();
                total++;
                if ({CHIP_CS, CHIP_WR, CHIP_AD, CHIP_DO} !== {4'(1 << c), 1'b1, 1'b0, bi[1], bd[1]}) begin
                    bad++;
                    $display("[TB] FAIL b2b_second%0d: got %h required %h", c,
                        {CHIP_CS, CHIP_WR, CHIP_AD, CHIP_DO}, {4'(1 << c), 1'b1, 1'b0, bi[1], bd[1]});
                end
            end
            step();
            total++;
            if ({CHIP_CS, CPU_WAIT, DROP} !== {4'h0, 1'b0, 1'b1}) begin
                bad++;
                $display("[TB] FAIL b2b_end: got %b required 000001", {CHIP_CS, CPU_WAIT, DROP});
            end
            strobe(1'b1, 5'h10, 8'h0F);
            total++;
            if (DROP !== 1'b0) begin
                bad++;
                $display("[TB] FAIL b2b_drop_clear: got %b required 0", DROP);
            end
            wait_idle();
        end

        newc = {4'b0000, 4'($urandom_range(1, 15))};
        strobe(1'b1, {1'b0, 4'($urandom)}, 8'($urandom));
        strobe(1'b1, 5'h10, newc);
        for (int c = 0; c < 3; c++) begin
            total++;
            if (CPU_DO !== 8'h0F) begin
                bad++;
                $display("[TB] FAIL queued_ctrl_hold: got %h required 0f", CPU_DO);
            end
            step();
        end
        total++;
        if ({CPU_DO, CHIP_CS} !== {8'h0F, 4'h0}) begin
            bad++;
            $display("[TB] FAIL queued_ctrl_gap: got %h required %h", {CPU_DO, CHIP_CS}, {8'h0F, 4'h0});
        end
        step();
        total++;
        if ({CPU_DO, CHIP_CS, CHIP_AD, CHIP_DO} !== {newc, lowest_onehot(newc[3:0]), 5'h10, newc}) begin
            bad++;
            $display("[TB] FAIL queued_ctrl_apply: got %h required %h",
                {CPU_DO, CHIP_CS, CHIP_AD, CHIP_DO}, {newc, lowest_onehot(newc[3:0]), 5'h10, newc});
        end
        wait_idle();
    endtask

    task automatic test_zero_mask();
        logic [31:0] lanes;
        logic [3:0]  idx;
        lanes = $urandom;
        lanes[7:0] = 8'h5A;
        idx = 4'($urandom);
        strobe(1'b1, 5'h10, 8'h11);
        wait_idle();
        CHIP_DI = lanes;
        strobe(1'b0, {1'b0, idx}, 8'h00);
        wait_idle();
        total++;
        if (CPU_DO !== 8'h5A) begin
            bad++;
            $display("[TB] FAIL zm_setup_read: got %h required 5a", CPU_DO);
        end
        strobe(1'b1, 5'h10, 8'h00);
        total++;
        if ({CHIP_CS, CPU_WAIT} !== 5'b0) begin
            bad++;
            $display("[TB] FAIL zm_ctrl_write: got %b required 00000", {CHIP_CS, CPU_WAIT});
        end
        strobe(1'b0, {1'b0, idx}, 8'h00);
        total++;
        if ({CHIP_CS, CPU_WAIT} !== {4'h0, 1'b1}) begin
            bad++;
            $display("[TB] FAIL zm_read_select: got %b required 00001", {CHIP_CS, CPU_WAIT});
        end
        step();
        total++;
        if (CPU_DO !== 8'hFF) begin
            bad++;
            $display("[TB] FAIL zm_read_data: got %h required ff", CPU_DO);
        end
        step();
        total++;
        if (CPU_WAIT !== 1'b0) begin
            bad++;
            $display("[TB] FAIL zm_read_done: got %b required 0", CPU_WAIT);
        end
        strobe(1'b0, 5'h10, 8'hAB);
        total++;
        if ({CPU_DO, CPU_WAIT, CHIP_CS} !== {8'h00, 1'b0, 4'h0}) begin
            bad++;
            $display("[TB] FAIL ctrl_read: got %h required %h", {CPU_DO, CPU_WAIT, CHIP_CS}, {8'h00, 1'b0, 4'h0});
        end
    endtask

    task automatic test_reset_midflight();
        strobe(1'b1, 5'h10, 8'h0F);
        wait_idle();
        strobe(1'b1, {1'b0, 4'($urandom)}, 8'($urandom));
        strobe(1'b1, {1'b0, 4'($urandom)}, 8'($urandom));
        total++;
        if (CHIP_CS !== 4'b0010) begin
            bad++;
            $display("[TB] FAIL mid_second_chip: got %b required 0010", CHIP_CS);
        end
        CPU_AD = 5'h10;
        #2;
        RESET = 1'b1;
        #1;
        total++;
        if ({CHIP_CS, CHIP_WR, CHIP_AD, CHIP_DO, CPU_WAIT, DROP, NMI, CPU_DO} !==
            {4'h0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            bad++;
            $display("[TB] FAIL mid_reset_outputs: got %h required %h",
                {CHIP_CS, CHIP_WR, CHIP_AD, CHIP_DO, CPU_WAIT, DROP, NMI, CPU_DO},
                {4'h0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00});
        end
        CPU_AD = 5'h00;
        #1;
        total++;
        if (CPU_DO !== 8'hFF) begin
            bad++;
            $display("[TB] FAIL mid_reset_rdata: got %h required ff", CPU_DO);
        end
        #1;
        RESET = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            total++;
            if ({CHIP_CS, CPU_WAIT} !== 5'b0) begin
                bad++;
                $display("[TB] FAIL mid_no_resume: got %b required 00000", {CHIP_CS, CPU_WAIT});
            end
        end
    endtask

    task automatic test_nmi();
        int   n1;
        logic exp;
        apply_reset();
        strobe(1'b1, 5'h10, 8'hE3);
        n1 = 4800 + $urandom_range(0, 2399);
        for (int k = 0; k < n1; k++) begin
            exp = ((k % PERIOD) >= (PERIOD - WIDTH));
            total++;
            if (NMI !== exp) begin
                bad++;
                $display("[TB] FAIL nmi_run k=%0d: got %b required %b", k, NMI, exp);
            end
            step();
        end
        strobe(1'b1, 5'h10, 8'h20);
        for (int k = 0; k < 2300; k++) begin
            exp = ((k % PERIOD) >= (PERIOD - WIDTH));
            total++;
            if (NMI !== exp) begin
                bad++;
                $display("[TB] FAIL nmi_restart k=%0d: got %b required %b", k, NMI, exp);
            end
            step();
        end
        total++;
        if (NMI !== 1'b1) begin
            bad++;
            $display("[TB] FAIL nmi_high_before_off: got %b required 1", NMI);
        end
        strobe(1'b1, 5'h10, 8'h10);
        for (int k = 0; k < 2500; k++) begin
            total++;
            if (NMI !== 1'b0) begin
                bad++;
                $display("[TB] FAIL nmi_off k=%0d: got %b required 0", k, NMI);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_broadcast();
        test_read();
        test_back_to_back();
        test_zero_mask();
        test_reset_midflight();
        test_nmi();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
